// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the 5-stage MIPS datapath.
// Captures the decoded control bundle and execute-stage operands, supports
// stall, flush and load-use bubble insertion, and counts inserted bubbles
// with a saturating counter.
// Optional feature macro: ID_EX_HAZARD_EN (load-use detection compiled in).
module id_ex_reg #(
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_id,
   input  logic             stall,
   input  logic             flush,
   input  logic             reg_dst_id,
   input  logic             branch_id,
   input  logic             mem_read_id,
   input  logic             mem_to_reg_id,
   input  logic             mem_write_id,
   input  logic             alu_src_id,
   input  logic             reg_write_id,
   input  logic [2:0]       alu_op_id,
   input  logic [DW-1:0]    pc4_id,
   input  logic [DW-1:0]    rd1_id,
   input  logic [DW-1:0]    rd2_id,
   input  logic [DW-1:0]    imm_id,
   input  logic [4:0]       rs_id,
   input  logic [4:0]       rt_id,
   input  logic [4:0]       rd_id,
   output logic             valid_ex,
   output logic             reg_dst_ex,
   output logic             branch_ex,
   output logic             mem_read_ex,
   output logic             mem_to_reg_ex,
   output logic             mem_write_ex,
   output logic             alu_src_ex,
   output logic             reg_write_ex,
   output logic [2:0]       alu_op_ex,
   output logic [DW-1:0]    pc4_ex,
   output logic [DW-1:0]    rd1_ex,
   output logic [DW-1:0]    rd2_ex,
   output logic [DW-1:0]    imm_ex,
   output logic [4:0]       rs_ex,
   output logic [4:0]       rt_ex,
   output logic [4:0]       rd_ex,
   output logic             hazard_stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef enum logic [1:0] {
      ACT_LOAD,
      ACT_HOLD,
      ACT_BUBBLE
   } act_e;

   // Control bundle order: reg_dst, branch, mem_read, mem_to_reg,
   // mem_write, alu_src, reg_write, alu_op[2:0]
   logic             r_valid;
   logic [9:0]       r_ctrl;
   logic [DW-1:0]    r_pc4;
   logic [DW-1:0]    r_rd1;
   logic [DW-1:0]    r_rd2;
   logic [DW-1:0]    r_imm;
   logic [4:0]       r_rs;
   logic [4:0]       r_rt;
   logic [4:0]       r_rd;
   logic [CNT_W-1:0] r_cnt;

   act_e             w_act;
   logic             w_hazard;
   logic             w_reg_dst;
   logic             w_mem_to_reg;
   logic [9:0]       w_ctrl_in;

   // RegDst and MemToReg may be X from the control unit; only a real 1 passes.
   assign w_reg_dst    = (reg_dst_id === 1'b1);
   assign w_mem_to_reg = (mem_to_reg_id === 1'b1);

   assign w_ctrl_in = valid_id ?
      {w_reg_dst, branch_id, mem_read_id, w_mem_to_reg, mem_write_id,
       alu_src_id, reg_write_id, alu_op_id} : '0;

`ifdef ID_EX_HAZARD_EN
   // Load in EX whose destination is a source of the instruction in ID.
   assign w_hazard = r_valid & r_ctrl[7] & (r_rt != 5'd0) &
                     ((r_rt == rs_id) | ((r_rt == rt_id) & ~alu_src_id));
`else
   assign w_hazard = 1'b0;
`endif

   // Per-edge decision: flush/hazard bubble beats stall beats load.
   always_comb begin
      w_act = ACT_LOAD;
      if (flush || w_hazard) begin
         w_act = ACT_BUBBLE;
      end else if (stall) begin
         w_act = ACT_HOLD;
      end
   end

   // Valid flag and control bundle; a bubble clears both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
      end else begin
         case (w_act)
            ACT_BUBBLE: begin
               r_valid <= 1'b0;
               r_ctrl  <= '0;
            end
            ACT_LOAD: begin
               r_valid <= valid_id;
               r_ctrl  <= w_ctrl_in;
            end
            default: ;
         endcase
      end
   end

   // Operands and specifiers load only on a plain load; bubbles leave them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc4 <= '0;
         r_rd1 <= '0;
         r_rd2 <= '0;
         r_imm <= '0;
         r_rs  <= '0;
         r_rt  <= '0;
         r_rd  <= '0;
      end else if (w_act == ACT_LOAD) begin
         r_pc4 <= pc4_id;
         r_rd1 <= rd1_id;
         r_rd2 <= rd2_id;
         r_imm <= imm_id;
         r_rs  <= rs_id;
         r_rt  <= rt_id;
         r_rd  <= rd_id;
      end
   end

   // Saturating count of bubbles inserted by flush or hazard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if ((w_act == ACT_BUBBLE) && !(&r_cnt)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign valid_ex      = r_valid;
   assign reg_dst_ex    = r_ctrl[9];
   assign branch_ex     = r_ctrl[8];
   assign mem_read_ex   = r_ctrl[7];
   assign mem_to_reg_ex = r_ctrl[6];
   assign mem_write_ex  = r_ctrl[5];
   assign alu_src_ex    = r_ctrl[4];
   assign reg_write_ex  = r_ctrl[3];
   assign alu_op_ex     = r_ctrl[2:0];
   assign pc4_ex        = r_pc4;
   assign rd1_ex        = r_rd1;
   assign rd2_ex        = r_rd2;
   assign imm_ex        = r_imm;
   assign rs_ex         = r_rs;
   assign rt_ex         = r_rt;
   assign rd_ex         = r_rd;
   assign hazard_stall  = w_hazard;
   assign bubble_cnt    = r_cnt;

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the 5-stage MIPS datapath. Sits directly downstream of the decode-stage control unit and register file. It captures the decoded control bundle (RegDst, Branch, MemRead, MemToReg, ALUOp, MemWrite, ALUSrc, RegWrite) plus the operands for the execute stage. It supports stall, flush and bubble insertion, and keeps a saturating bubble counter for performance monitoring.

## Interface
Parameters:
- `DW`, default 32: datapath width of PC, operands and immediate.
- `CNT_W`, default 16: width of the bubble counter.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `valid_id` in 1: decode stage holds a real instruction.
- `stall` in 1: hold all ID/EX contents.
- `flush` in 1: replace the next ID/EX contents with a bubble (branch taken).
- `reg_dst_id`, `branch_id`, `mem_read_id`, `mem_to_reg_id`, `mem_write_id`, `alu_src_id`, `reg_write_id` in 1 each: control from the control unit.
- `alu_op_id` in 3: ALU operation class from the control unit.
- `pc4_id` in DW: PC+4.
- `rd1_id`, `rd2_id` in DW: register-file read data.
- `imm_id` in DW: sign-extended immediate; bits [5:0] are the funct field.
- `rs_id`, `rt_id`, `rd_id` in 5: register specifiers.
- All `*_id` signals have a registered `*_ex` output of the same width.
- `valid_ex` out 1: the EX slot holds a real instruction.
- `hazard_stall` out 1: load-use stall request to PC and IF/ID (combinational).
- `bubble_cnt` out CNT_W: number of bubbles inserted, saturating.

## Operation
- Decision order, evaluated at every rising edge, highest priority first:
  1. Flush: `flush`=1 loads a bubble.
  2. Hazard: `hazard_stall`=1 loads a bubble.
  3. Stall: `stall`=1 holds every register unchanged, including `valid_ex`.
  4. Load: otherwise, all `*_ex` outputs take their `*_id` inputs, and `valid_ex` takes `valid_id`.
- Bubble contents:
  - `valid_ex`=0.
  - All 1-bit control outputs = 0.
  - `alu_op_ex`=3'b000.
  - Data and specifier outputs keep their previous values; they are don't-care.
- Load with `valid_id`=0: control outputs are forced to 0 exactly as for a bubble, and data is loaded.
- Load with `valid_id`=1: control passes through unmodified. An X on `reg_dst_id` or `mem_to_reg_id` is sanitized to 0. An X on any other control bit is a protocol violation.
- Bubble counter:
  - Increments by 1 on each edge where a bubble is loaded by flush or hazard. A plain load with `valid_id`=0 does not count.
  - Saturates at 2^CNT_W−1; it does not wrap.
  - Cleared only by reset.
- Simultaneous events:
  - `flush` and `stall` both 1: flush wins and the bubble is loaded.
  - `flush` and `hazard_stall` both 1: one bubble is loaded and the counter increments by one.

## Timing
- Latency: one cycle from `*_id` to `*_ex`.
- Asserting `rst_n`=0 immediately, with no clock required, forces:
  - `valid_ex`, all control outputs and `alu_op_ex` to 0.
  - All data and specifier outputs to 0.
  - `bubble_cnt` to 0.
- Reset applied mid-operation discards the in-flight instruction. The first edge after deassertion performs the normal decision order.
- `hazard_stall` is combinational from `*_ex` and `rs_id`/`rt_id`; it has no registered delay.
- Upstream must hold IF/ID in the same cycle `hazard_stall` is high.
- A load-use hazard produces exactly one bubble. Its EX copy has `valid_ex`=0, so the next cycle's `hazard_stall` is 0.

## Configuration
- Macro: `ID_EX_HAZARD_EN`.
- Defined: load-use detection is compiled in. `hazard_stall` = `valid_ex` & `mem_read_ex` & (`rt_ex`≠0) & (`rt_ex`==`rs_id` | (`rt_ex`==`rt_id` & !`alu_src_id`)). When asserted, the block inserts its own bubble.
- Undefined: `hazard_stall` is tied to 0, and bubbles come only from `flush`.

## Test plan
- Reset: pulse `rst_n` low mid-cycle with no clock → all outputs 0 immediately; `bubble_cnt`=0.
- Normal load: R-type control (RegDst=1, RegWrite=1, ALUOp=3'b101), `rd1_id`=32'h5, `valid_id`=1 → next edge gives `reg_dst_ex`=1, `alu_op_ex`=3'b101, `rd1_ex`=32'h5, `valid_ex`=1.
- Stall/flush priority:
  - `stall`=1 for 3 edges with changing inputs → outputs unchanged.
  - Then `stall`=1 and `flush`=1 together → bubble, `reg_write_ex`=0, `bubble_cnt`=1.
- Load-use (macro defined):
  - lw with `rt`=8 in EX, then add with `rs_id`=8 → `hazard_stall`=1 for exactly one cycle, one bubble, `bubble_cnt`+1.
  - Same sequence with `rt_ex`=0 → no stall.
- Saturation: CNT_W=4, 20 flushes → `bubble_cnt`=15.
- Invalid decode: `valid_id`=0 with MemWrite=1 → `mem_write_ex`=0, `valid_ex`=0, counter unchanged.
